// File: rtl/jtag_dr_tx_if.sv
// jtag_dr_tx_if -- word handshake between the clk48m-domain producer and
// the JTAG data-register transmitter.
//
// Signals:
//   tx_data  : word to send to the host (WIDTH bits)
//   tx_sel   : chain that consumes the word (0 = ER1, 1 = ER2)
//   tx_valid : single-cycle write strobe from the producer
//   tx_ready : holding register empty, driven by the transmitter
//   tx_done  : one-cycle pulse when the host has fully read the word
//
// Modports:
//   master : producer side (drives data/sel/valid)
//   slave  : transmitter side (drives ready/done)

interface jtag_dr_tx_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_sel;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_done;

  modport master (
    output tx_data,
    output tx_sel,
    output tx_valid,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_sel,
    input  tx_valid,
    output tx_ready,
    output tx_done
  );

endinterface

// File: rtl/jtag_dr_tx.sv
// jtag_dr_tx -- sends one WIDTH-bit word to a JTAG host through the JTAGG
// ER1 or ER2 data register. The producer writes a word into a holding
// register; when the host captures the matching chain and shifts all WIDTH
// bits out, the word is consumed and tx_done pulses.
//
// Ports:
//   clk, rstn        : clk48m system clock, asynchronous active-low reset
//   jtck             : JTAGG JTCK, asynchronous to clk (at most clk/8)
//   jshift, jupdate  : JTAGG Shift-DR / Update-DR status
//   jce1, jce2       : JTAGG ER1 / ER2 capture-shift enables
//   jrstn            : JTAGG test-logic reset, active low
//   tx               : producer handshake (slave modport)
//   jtdo1, jtdo2     : JTAGG JTDO1 / JTDO2

module jtag_dr_tx #(
  parameter int WIDTH = 32,
  parameter int SYNC  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jtck,
  input  logic        jshift,
  input  logic        jupdate,
  input  logic        jce1,
  input  logic        jce2,
  input  logic        jrstn,
  jtag_dr_tx_if.slave tx,
  output logic        jtdo1,
  output logic        jtdo2
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Bit order of the bundled JTAG status inputs.
  localparam int B_TCK  = 0;
  localparam int B_SHF  = 1;
  localparam int B_UPD  = 2;
  localparam int B_CE1  = 3;
  localparam int B_CE2  = 4;
  localparam int B_RSTN = 5;

  logic [5:0]       jtag_pins;
  logic [5:0]       sync_q [SYNC];
  logic [5:0]       jtag_s;
  logic             jtck_prev;
  logic             tck_rise;
  logic             tck_fall;
  logic             capture;

  state_t           state;
  logic [WIDTH-1:0] hold_data;
  logic             hold_sel;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             chain;
  logic             match;

  assign jtag_pins = {jrstn, jce2, jce1, jupdate, jshift, jtck};
  assign jtag_s    = sync_q[SYNC-1];

  // Edges come from the synchronized jtck and its one-clk-older copy, so
  // every action lands one clk after the synchronized level changes.
  assign tck_rise = jtag_s[B_TCK] & ~jtck_prev;
  assign tck_fall = ~jtag_s[B_TCK] & jtck_prev;
  assign capture  = (jtag_s[B_CE1] | jtag_s[B_CE2]) & ~jtag_s[B_SHF];

  assign tx.tx_ready = ready_q;
  assign tx.tx_done  = done_q;

  // Multi-flop synchronizer chain for all JTAG inputs, plus the extra jtck
  // stage used for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC; i++) begin
        sync_q[i] <= '0;
      end
      jtck_prev <= 1'b0;
    end else begin
      sync_q[0] <= jtag_pins;
      for (int i = 1; i < SYNC; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      jtck_prev <= jtag_s[B_TCK];
    end
  end

  // Holding register, capture/shift/update FSM and TDO drivers.
  // tx_done is raised at the consuming update and tx_ready only returns
  // high on the following cycle, so a write strobe coinciding with tx_done
  // still sees a full holding register and is dropped.
  // A JTAG test-logic reset aborts any transfer but leaves the pending word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_sel  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      chain     <= 1'b0;
      match     <= 1'b0;
      jtdo1     <= 1'b0;
      jtdo2     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (done_q) begin
        ready_q   <= 1'b1;
        hold_data <= '0;
        hold_sel  <= 1'b0;
      end else if (tx.tx_valid && ready_q) begin
        hold_data <= tx.tx_data;
        hold_sel  <= tx.tx_sel;
        ready_q   <= 1'b0;
      end

      if (!jtag_s[B_RSTN]) begin
        state <= IDLE;
        shreg <= '0;
        cnt   <= '0;
        match <= 1'b0;
        jtdo1 <= 1'b0;
        jtdo2 <= 1'b0;
      end else begin
        if (tck_rise) begin
          if (capture) begin
            chain <= jtag_s[B_CE2];
            cnt   <= '0;
            state <= SHIFT;
            if (!ready_q && (hold_sel == jtag_s[B_CE2])) begin
              shreg <= hold_data;
              match <= 1'b1;
            end else begin
              shreg <= '0;
              match <= 1'b0;
            end
          end else if (state == SHIFT && jtag_s[B_SHF]) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            if (cnt != CW'(WIDTH)) begin
              cnt <= cnt + 1'b1;
            end
          end else if (state == SHIFT && jtag_s[B_UPD]) begin
            state <= IDLE;
            match <= 1'b0;
            if (match && cnt == CW'(WIDTH)) begin
              done_q <= 1'b1;
            end
          end
        end

        if (tck_fall) begin
          jtdo1 <= ~chain & shreg[0];
          jtdo2 <=  chain & shreg[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dr_tx.sv
// tb_jtag_dr_tx -- directed bench for jtag_dr_tx: a vector table of
// write/read transactions followed by hand-written corner sequences
// (busy write, shift past WIDTH, write during tx_done, jrstn abort,
// rstn abort mid-shift).

module tb_jtag_dr_tx;

  logic clk;
  logic rstn;
  logic jtck;
  logic jshift;
  logic jupdate;
  logic jce1;
  logic jce2;
  logic jrstn;
  logic jtdo1;
  logic jtdo2;

  int tests_run;
  int tests_failed;
  int done_count;

  jtag_dr_tx_if #(.WIDTH(32)) tx_if ();

  jtag_dr_tx #(.WIDTH(32), .SYNC(2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .jtck    (jtck),
    .jshift  (jshift),
    .jupdate (jupdate),
    .jce1    (jce1),
    .jce2    (jce2),
    .jrstn   (jrstn),
    .tx      (tx_if),
    .jtdo1   (jtdo1),
    .jtdo2   (jtdo2)
  );

  typedef struct {
    string       name;
    logic        do_write;
    logic [31:0] word;
    logic        sel;
    logic        chain;
    int          nbits;
    logic [31:0] exp_val;
    int          exp_done;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [6];

  // 100 MHz-ish system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every clk cycle in which tx_done is high
  always @(negedge clk) begin
    if (tx_if.tx_done === 1'b1) done_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full TCK cycle with the given status levels; tdo is valid at return
  task automatic applyStimulus(input logic ce1, input logic ce2,
                               input logic shf, input logic upd);
    jce1    = ce1;
    jce2    = ce2;
    jshift  = shf;
    jupdate = upd;
    repeat (4) @(negedge clk);
    jtck = 1'b1;
    repeat (8) @(negedge clk);
    jtck = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic writeWord(input logic [31:0] word, input logic sel);
    @(negedge clk);
    tx_if.tx_data  = word;
    tx_if.tx_sel   = sel;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Capture on the chosen chain, shift nbits, optionally update.
  // val gets the first 32 bits seen on the selected tdo, other_seen ORs the
  // unselected tdo, extra_seen ORs any selected-tdo bit beyond bit 31.
  task automatic readChain(input logic ch, input int nbits, input logic do_upd,
                           output logic [31:0] val, output logic other_seen,
                           output logic extra_seen);
    logic cur;
    logic oth;
    val        = '0;
    other_seen = 1'b0;
    extra_seen = 1'b0;
    applyStimulus(~ch, ch, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      cur = ch ? jtdo2 : jtdo1;
      oth = ch ? jtdo1 : jtdo2;
      if (i < 32) val[i] = cur;
      else extra_seen = extra_seen | cur;
      other_seen = other_seen | oth;
      applyStimulus(~ch, ch, 1'b1, 1'b0);
    end
    if (do_upd) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    jce1   = 1'b0;
    jce2   = 1'b0;
    jshift = 1'b0;
    jupdate = 1'b0;
  endtask

  initial begin
    logic [31:0] val;
    logic        oth;
    logic        ext;
    logic        seen;
    int          d0;

    tests_run    = 0;
    tests_failed = 0;
    done_count   = 0;

    vecs[0] = '{"er1_full",      1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32, 32'hA5A5_0001, 1, 1'b1};
    vecs[1] = '{"er2_partial",   1'b1, 32'h1234_5678, 1'b1, 1'b1,  8, 32'h0000_0078, 0, 1'b0};
    vecs[2] = '{"er2_retry",     1'b0, 32'h0,         1'b0, 1'b1, 32, 32'h1234_5678, 1, 1'b1};
    vecs[3] = '{"wrong_chain",   1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32, 32'h0000_0000, 0, 1'b0};
    vecs[4] = '{"right_chain",   1'b0, 32'h0,         1'b0, 1'b0, 32, 32'hDEAD_BEEF, 1, 1'b1};
    vecs[5] = '{"empty_read",    1'b0, 32'h0,         1'b0, 1'b0, 32, 32'h0000_0000, 0, 1'b1};

    rstn = 1'b0;
    jtck = 1'b0; jshift = 1'b0; jupdate = 1'b0;
    jce1 = 1'b0; jce2 = 1'b0; jrstn = 1'b1;
    tx_if.tx_data = '0; tx_if.tx_sel = 1'b0; tx_if.tx_valid = 1'b0;

    repeat (4) @(negedge clk);
    checkOutput("reset_ready", {31'b0, tx_if.tx_ready}, 32'd1);
    checkOutput("reset_done",  {31'b0, tx_if.tx_done},  32'd0);
    checkOutput("reset_tdo1",  {31'b0, jtdo1},          32'd0);
    checkOutput("reset_tdo2",  {31'b0, jtdo2},          32'd0);
    rstn = 1'b1;
    repeat (6) @(negedge clk);

    // Table-driven transactions
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_write) writeWord(vecs[v].word, vecs[v].sel);
      d0 = done_count;
      readChain(vecs[v].chain, vecs[v].nbits, 1'b1, val, oth, ext);
      repeat (4) @(negedge clk);
      checkOutput({vecs[v].name, "_data"},  val, vecs[v].exp_val);
      checkOutput({vecs[v].name, "_other"}, {31'b0, oth}, 32'd0);
      checkOutput({vecs[v].name, "_done"},  done_count - d0, vecs[v].exp_done);
      checkOutput({vecs[v].name, "_ready"}, {31'b0, tx_if.tx_ready}, {31'b0, vecs[v].exp_ready});
    end

    // Write while busy is ignored
    writeWord(32'h0BAD_F00D, 1'b0);
    writeWord(32'h1111_1111, 1'b1);
    checkOutput("busy_ready", {31'b0, tx_if.tx_ready}, 32'd0);
    d0 = done_count;
    readChain(1'b0, 32, 1'b1, val, oth, ext);
    repeat (4) @(negedge clk);
    checkOutput("busy_data", val, 32'h0BAD_F00D);
    checkOutput("busy_done", done_count - d0, 32'd1);

    // Shifting past WIDTH outputs zeros and still completes
    writeWord(32'hFFFF_FFFF, 1'b0);
    d0 = done_count;
    readChain(1'b0, 35, 1'b1, val, oth, ext);
    repeat (4) @(negedge clk);
    checkOutput("over_data",  val, 32'hFFFF_FFFF);
    checkOutput("over_extra", {31'b0, ext}, 32'd0);
    checkOutput("over_done",  done_count - d0, 32'd1);

    // tx_valid in the tx_done cycle is dropped
    writeWord(32'hCAFE_F00D, 1'b1);
    readChain(1'b1, 32, 1'b0, val, oth, ext);
    checkOutput("coinc_data", val, 32'hCAFE_F00D);
    jupdate = 1'b1;
    repeat (4) @(negedge clk);
    jtck = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (tx_if.tx_done === 1'b1) begin
        seen = 1'b1;
        tx_if.tx_data  = 32'h5555_AAAA;
        tx_if.tx_sel   = 1'b0;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
      end
    end
    checkOutput("coinc_done_seen", {31'b0, seen}, 32'd1);
    repeat (8) @(negedge clk);
    jtck = 1'b0;
    jupdate = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("coinc_ready", {31'b0, tx_if.tx_ready}, 32'd1);
    d0 = done_count;
    readChain(1'b0, 32, 1'b1, val, oth, ext);
    repeat (4) @(negedge clk);
    checkOutput("coinc_nolatch", val, 32'h0);
    checkOutput("coinc_nodone",  done_count - d0, 32'd0);

    // jrstn pulse mid-shift aborts, word survives for the retry
    writeWord(32'h600D_CEFE, 1'b0);
    d0 = done_count;
    readChain(1'b0, 10, 1'b0, val, oth, ext);
    checkOutput("jrst_pre_tdo", {31'b0, jtdo1}, 32'd1);
    jrstn = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("jrst_tdo", {31'b0, jtdo1}, 32'd0);
    jrstn = 1'b1;
    repeat (8) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("jrst_nodone", done_count - d0, 32'd0);
    checkOutput("jrst_ready",  {31'b0, tx_if.tx_ready}, 32'd0);
    readChain(1'b0, 32, 1'b1, val, oth, ext);
    repeat (4) @(negedge clk);
    checkOutput("jrst_retry", val, 32'h600D_CEFE);
    checkOutput("jrst_done",  done_count - d0, 32'd1);

    // rstn during the 16th shift bit
    writeWord(32'hFFFF_FFFF, 1'b1);
    d0 = done_count;
    readChain(1'b1, 15, 1'b0, val, oth, ext);
    jce2 = 1'b1;
    jshift = 1'b1;
    repeat (4) @(negedge clk);
    jtck = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_tdo2", {31'b0, jtdo2}, 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("rst_ready", {31'b0, tx_if.tx_ready}, 32'd1);
    checkOutput("rst_done",  {31'b0, tx_if.tx_done},  32'd0);
    checkOutput("rst_tdo1",  {31'b0, jtdo1},          32'd0);
    checkOutput("rst_tdo2",  {31'b0, jtdo2},          32'd0);
    repeat (4) @(negedge clk);
    jtck = 1'b0; jce2 = 1'b0; jshift = 1'b0;
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rst_nodone", done_count - d0, 32'd0);
    readChain(1'b1, 32, 1'b1, val, oth, ext);
    repeat (4) @(negedge clk);
    checkOutput("rst_empty", val, 32'h0);
    checkOutput("rst_ready_after", {31'b0, tx_if.tx_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jtag_dr_tx.md
JTAG_DR_TX -- requirements
Module: jtag_dr_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data register length in bits.
REQ-002 SHALL have parameter SYNC, default 2: synchronizer flops on jtck, jshift, jupdate, jce1, jce2 and jrstn.
REQ-003 SHALL have port clk, input, 1: system clock (clk48m domain).
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port jtck, input, 1: JTAGG JTCK, asynchronous to clk.
REQ-006 SHALL have ports jshift, jupdate, jce1, jce2, jrstn, input, 1 each: JTAGG status signals, asynchronous to clk.
REQ-007 SHALL have port tx_data, input, WIDTH: word to send to the host.
REQ-008 SHALL have port tx_sel, input, 1: chain that consumes the word (0 = ER1/IR 0x32, 1 = ER2/IR 0x38).
REQ-009 SHALL have port tx_valid, input, 1: single-cycle write strobe.
REQ-010 SHALL have port tx_ready, output, 1: holding register empty.
REQ-011 SHALL have port tx_done, output, 1: one-cycle pulse when the host has fully read the word.
REQ-012 SHALL have ports jtdo1 and jtdo2, output, 1 each: JTAGG JTDO1 and JTDO2.

Function
REQ-013 SHALL synchronize all JTAG inputs through SYNC flops.
REQ-014 SHALL detect a TCK rising event (rise) and a TCK falling event (fall) from the last two synchronized jtck samples.
REQ-015 SHALL act on an edge 1 clk after the synchronized jtck changes; jtck SHALL be at most clk/8.
REQ-016 SHALL accept a write when tx_valid=1 and tx_ready=1: latch tx_data and tx_sel into the holding register, then drive tx_ready=0 on the next cycle.
REQ-017 SHALL ignore tx_valid while tx_ready=0, leaving the holding register unchanged.
REQ-018 SHALL implement FSM states IDLE and SHIFT.
REQ-019 SHALL, on rise with (jce1|jce2)=1 and jshift=0 (Capture-DR):
- set chain = jce2;
- load the shift register with the held word if tx_ready=0 and held sel==chain, else with all zeros;
- clear the bit counter;
- set match = (tx_ready=0 and held sel==chain);
- go to SHIFT.
REQ-020 SHALL, on rise in SHIFT with jshift=1:
- shift the register right, filling the MSB with 0;
- increment the bit counter, saturating at WIDTH.
REQ-021 SHALL, on every fall, drive the selected chain's tdo from shift register bit 0; the unselected tdo SHALL be 0.
REQ-022 SHALL, on rise in SHIFT with jupdate=1, return to IDLE; if match=1 and the counter equals WIDTH, clear the holding register (tx_ready=1 on the next cycle) and pulse tx_done for exactly 1 cycle.
REQ-023 SHALL, on an update with counter < WIDTH (partial read), keep the held word pending so it is re-sent on the next capture.
REQ-024 SHALL let a consumption at REQ-022 take priority when tx_valid arrives in the same cycle; the write SHALL be dropped because tx_ready was 0.
REQ-025 SHALL, after the counter reaches WIDTH, output 0 on further shifts.
REQ-026 SHALL, on synchronized jrstn=0, go to IDLE, zero the shift register, counter and tdo outputs, and keep the holding register and tx_ready.
REQ-027 SHALL, on a capture from the other chain while a word is pending, load zeros and leave the pending word intact.

Reset
REQ-028 SHALL, while rstn=0, force: state IDLE, tx_ready=1, tx_done=0, jtdo1=0, jtdo2=0, shift register 0, counter 0, synchronizers 0.
REQ-029 SHALL, when rstn=0 arrives mid-shift, abort the shift immediately with no tx_done.

Verification
REQ-030 Write 0xA5A5_0001 with sel=0, then ER1 capture + 32 shifts + update -> jtdo1 sequence LSB-first 1,0,0,...; tx_done pulses once; tx_ready=1.
REQ-031 Write 0x1234_5678 with sel=1, ER2 capture + 8 shifts + update -> jtdo2 yields 0x78 LSB-first; no tx_done; a second full read returns 0x1234_5678 and then tx_done pulses.
REQ-032 Word pending with sel=0, ER2 capture + 32 shifts -> jtdo2 all 0; jtdo1 stays 0; tx_ready stays 0.
REQ-033 tx_valid asserted in the same cycle as tx_done -> new word is not latched; tx_ready=1 afterwards.
REQ-034 jrstn pulsed low mid-shift, then a full ER1 read -> first read aborted with no tx_done; the pending word is delivered intact on the retry.
REQ-035 rstn asserted during the 16th shift bit -> all outputs return to reset values within 0 clk; tx_ready=1.
